// File: rtl/peristaltic_pump_ctrl.sv
// Three-valve peristaltic pump sequencer: 6-phase valve pattern with programmable dwell, direction and cycle count.
// Phase pattern appears the clock after start; all outputs are registered, and reset forces every valve closed at once.
module peristaltic_pump_ctrl #(
    parameter int DWELL_W = 16,
    parameter int CNT_W   = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_dir,
    input  logic               i_pause,
    input  logic               i_abort,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic [CNT_W-1:0]   i_n_cycles,
    output logic [2:0]         o_valve_ctrl,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_aborted,
    output logic [CNT_W-1:0]   o_cycle_count,
    output logic [2:0]         o_phase
);

    typedef enum logic [1:0] {S_IDLE, S_PUMP, S_SETTLE, S_DONE} state_t;

    localparam logic [DWELL_W-1:0] DW_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [2:0]         ALL_CLOSED = 3'b111;

    state_t             r_state;
    logic               r_dir;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic [CNT_W-1:0]   r_n_cycles;
    logic [CNT_W-1:0]   r_cycle_cnt;
    logic [2:0]         r_phase;
    logic [2:0]         r_valve;
    logic               r_busy;
    logic               r_done;
    logic               r_aborted;

    logic               w_dwell_end;
    logic [2:0]         w_next_phase;
    logic               w_cycle_end;
    logic [CNT_W-1:0]   w_cycle_inc;

    // Gray-like ring: exactly one valve toggles between neighbouring phases.
    function automatic logic [2:0] f_pattern(input logic [2:0] p);
        case (p)
            3'd0:    f_pattern = 3'b110;
            3'd1:    f_pattern = 3'b100;
            3'd2:    f_pattern = 3'b101;
            3'd3:    f_pattern = 3'b001;
            3'd4:    f_pattern = 3'b011;
            3'd5:    f_pattern = 3'b010;
            default: f_pattern = ALL_CLOSED;
        endcase
    endfunction

    always_comb begin
        w_dwell_end  = (r_dwell_cnt == (r_dwell - DW_ONE));
        if (r_dir)
            w_next_phase = (r_phase == 3'd0) ? 3'd5 : (r_phase - 3'd1);
        else
            w_next_phase = (r_phase == 3'd5) ? 3'd0 : (r_phase + 3'd1);
        w_cycle_end  = (w_next_phase == 3'd0);
        w_cycle_inc  = r_cycle_cnt + CNT_ONE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_dir       <= 1'b0;
            r_dwell     <= DW_ONE;
            r_dwell_cnt <= '0;
            r_n_cycles  <= '0;
            r_cycle_cnt <= '0;
            r_phase     <= 3'd0;
            r_valve     <= ALL_CLOSED;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_valve <= ALL_CLOSED;
                    r_done  <= 1'b0;
                    if (i_start) begin
                        r_dir       <= i_dir;
                        r_dwell     <= (i_dwell == '0) ? DW_ONE : i_dwell;
                        r_n_cycles  <= i_n_cycles;
                        r_cycle_cnt <= '0;
                        r_aborted   <= 1'b0;
                        r_dwell_cnt <= '0;
                        r_phase     <= 3'd0;
                        if (i_n_cycles == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_PUMP;
                            r_busy  <= 1'b1;
                            r_valve <= f_pattern(3'd0);
                        end
                    end
                end
                S_PUMP: begin
                    if (i_abort) begin
                        r_state     <= S_SETTLE;
                        r_aborted   <= 1'b1;
                        r_valve     <= ALL_CLOSED;
                        r_phase     <= 3'd0;
                        r_dwell_cnt <= '0;
                    end else if (!i_pause) begin
                        if (w_dwell_end) begin
                            r_dwell_cnt <= '0;
                            if (w_cycle_end && (w_cycle_inc == r_n_cycles)) begin
                                r_cycle_cnt <= w_cycle_inc;
                                r_state     <= S_SETTLE;
                                r_valve     <= ALL_CLOSED;
                                r_phase     <= 3'd0;
                            end else begin
                                if (w_cycle_end)
                                    r_cycle_cnt <= w_cycle_inc;
                                r_phase <= w_next_phase;
                                r_valve <= f_pattern(w_next_phase);
                            end
                        end else begin
                            r_dwell_cnt <= r_dwell_cnt + DW_ONE;
                        end
                    end
                end
                S_SETTLE: begin
                    r_valve <= ALL_CLOSED;
                    if (w_dwell_end) begin
                        r_dwell_cnt <= '0;
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_dwell_cnt <= r_dwell_cnt + DW_ONE;
                    end
                end
                S_DONE: begin
                    r_valve <= ALL_CLOSED;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valve <= ALL_CLOSED;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_valve_ctrl  = r_valve;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_aborted     = r_aborted;
    assign o_cycle_count = r_cycle_cnt;
    assign o_phase       = r_phase;

endmodule

// File: tb/tb_peristaltic_pump_ctrl.sv
// Bench for peristaltic_pump_ctrl: directed and randomized runs against a slot-based reference model.
module tb_peristaltic_pump_ctrl;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic        dir    = 1'b0;
    logic        pause  = 1'b0;
    logic        abort  = 1'b0;
    logic [15:0] dwell  = 16'd0;
    logic [15:0] ncyc   = 16'd0;
    logic [2:0]  valve_ctrl;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] cycle_count;
    logic [2:0]  phase;

    int n_chk  = 0;
    int n_fail = 0;

    logic [2:0] PAT [6] = '{3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010};

    peristaltic_pump_ctrl #(.DWELL_W(16), .CNT_W(16)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_dir        (dir),
        .i_pause      (pause),
        .i_abort      (abort),
        .i_dwell      (dwell),
        .i_n_cycles   (ncyc),
        .o_valve_ctrl (valve_ctrl),
        .o_busy       (busy),
        .o_done       (done),
        .o_aborted    (aborted),
        .o_cycle_count(cycle_count),
        .o_phase      (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One run: slot j walks 0..6nD-1; pattern index comes from j/D, cycle count from j/(6D).
    task automatic run(input bit d, input int dw, input int n, input int ps, input int pl,
                       input int ab, input bit spam, output int done_r);
        int  D;
        int  total;
        int  j;
        int  rem;
        int  mode;
        int  cc_fin;
        int  k;
        int  idx;
        bit  exp_ab;
        logic [2:0] e_valve;
        logic [2:0] e_phase;
        logic       e_busy;
        logic       e_done;
        int         e_cc;
        D      = (dw == 0) ? 1 : dw;
        total  = 6 * n * D;
        j      = 0;
        rem    = 0;
        exp_ab = 1'b0;
        cc_fin = n;
        done_r = -1;
        @(negedge clk);
        dir   = d;
        dwell = 16'(dw);
        ncyc  = 16'(n);
        start = 1'b1;
        pause = 1'b0;
        abort = 1'b0;
        mode  = (total == 0) ? 2 : 0;
        for (int r = 1; r < 3000; r++) begin
            @(negedge clk);
            start = 1'b0;
            dir   = 1'($urandom);
            dwell = 16'($urandom);
            ncyc  = 16'($urandom);
            if (mode == 0) begin
                k       = (j / D) % 6;
                idx     = d ? ((6 - k) % 6) : k;
                e_valve = PAT[idx];
                e_phase = 3'(idx);
                e_busy  = 1'b1;
                e_done  = 1'b0;
                e_cc    = j / (6 * D);
            end else begin
                e_valve = 3'b111;
                e_phase = 3'd0;
                e_busy  = (mode == 1);
                e_done  = (mode == 2);
                e_cc    = cc_fin;
            end
            chk("valve_ctrl",  32'(valve_ctrl),  32'(e_valve));
            chk("phase",       32'(phase),       32'(e_phase));
            chk("busy",        32'(busy),        32'(e_busy));
            chk("done",        32'(done),        32'(e_done));
            chk("cycle_count", 32'(cycle_count), 32'(e_cc));
            chk("aborted",     32'(aborted),     32'(exp_ab));
            if (mode == 2) begin
                done_r = r;
                break;
            end
            if (mode == 0) begin
                pause = (r >= ps) && (r < ps + pl);
                abort = (r == ab);
                if (spam) start = 1'($urandom);
                if (abort) begin
                    mode   = 1;
                    rem    = D;
                    cc_fin = j / (6 * D);
                    exp_ab = 1'b1;
                end else if (!pause) begin
                    j++;
                    if (j == total) begin
                        mode = 1;
                        rem  = D;
                    end
                end
            end else begin
                start = 1'b0;
                pause = 1'($urandom);
                abort = 1'($urandom);
                rem--;
                if (rem == 0) mode = 2;
            end
        end
        pause = 1'b0;
        abort = 1'b0;
        chk("done_seen", 32'(done_r >= 0), 32'd1);
        @(negedge clk);
        chk("idle_valve",   32'(valve_ctrl),  32'h7);
        chk("idle_busy",    32'(busy),        32'd0);
        chk("idle_done",    32'(done),        32'd0);
        chk("idle_aborted", 32'(aborted),     32'(exp_ab));
        chk("idle_cc",      32'(cycle_count), 32'(cc_fin));
    endtask

    initial begin
        int t_fwd;
        int t_rev;
        int t_base;
        int t_pause;
        int t_ab;
        int t_tmp;
        int rd;
        int rn;
        int rtot;
        int rab;
        int rps;
        int rpl;

        #12;
        chk("rst_valve", 32'(valve_ctrl),  32'h7);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_done",  32'(done),        32'd0);
        chk("rst_abrt",  32'(aborted),     32'd0);
        chk("rst_cc",    32'(cycle_count), 32'd0);
        chk("rst_phase", 32'(phase),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(1'b0, 2, 1, 0, 0, 0, 1'b0, t_fwd);
        chk("fwd_done_latency", 32'(t_fwd), 32'd15);

        run(1'b1, 0, 2, 0, 0, 0, 1'b0, t_rev);
        chk("rev_done_latency", 32'(t_rev), 32'd14);

        run(1'b0, 3, 1, 0, 0, 0, 1'b0, t_base);
        run(1'b0, 3, 1, 8, 5, 0, 1'b0, t_pause);
        chk("pause_delay", 32'(t_pause - t_base), 32'd5);

        run(1'b0, 1, 3, 0, 0, 11, 1'b0, t_ab);
        chk("abort_done_latency", 32'(t_ab), 32'd13);

        run(1'b0, 1, 0, 0, 0, 0, 1'b0, t_tmp);
        chk("zero_cycles_done", 32'(t_tmp), 32'd1);

        run(1'b1, 2, 2, 0, 0, 0, 1'b1, t_tmp);
        chk("start_spam_done", 32'(t_tmp), 32'd27);

        // Reset dropped between clock edges in the middle of P3.
        @(negedge clk);
        dir   = 1'b0;
        dwell = 16'd4;
        ncyc  = 16'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        chk("pre_rst_p3", 32'(valve_ctrl), 32'b001);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valve", 32'(valve_ctrl),  32'h7);
        chk("async_busy",  32'(busy),        32'd0);
        chk("async_phase", 32'(phase),       32'd0);
        chk("async_cc",    32'(cycle_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(1'b0, 1, 1, 0, 0, 0, 1'b0, t_tmp);
        chk("post_rst_done", 32'(t_tmp), 32'd8);

        for (int i = 0; i < 8; i++) begin
            rd   = int'($urandom_range(3, 0));
            rn   = int'($urandom_range(3, 0));
            rtot = 6 * rn * ((rd == 0) ? 1 : rd);
            rab  = (rtot > 0 && ($urandom % 3 == 0)) ? int'($urandom_range(rtot, 1)) : 0;
            rps  = int'($urandom_range(rtot + 1, 1));
            rpl  = int'($urandom_range(4, 0));
            run(1'($urandom), rd, rn, rps, rpl, rab, 1'($urandom), t_tmp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
